ccff_chain_loader: RTL
======================

// Module: ccff_chain_loader
// PURPOSE
//  Upstream driver of the configuration-chain head (ccff_head) of the switch/connection-block tile chain.
//  Accepts bitstream words over a valid/ready interface and serialises them MSB-first onto ccff_head.
//  Drives a chain clock enable (chain_clk_en) for the prog_clk gate, so the chain advances only on valid bits.
//  Stops after exactly CHAIN_LEN bits and flags completion.
// PARAMETERS
//  CHAIN_LEN  1024  total config bits in the downstream chain (>=1)
//  WORD_W     32    bitstream word width (>=2)
//  CNT_W      16    bit counter width; must satisfy 2**CNT_W > CHAIN_LEN
// PORTS
//  prog_clk      in   1       programming clock; all state on rising edge
//  prog_reset_n  in   1       synchronous, active-low reset
//  start         in   1       1-cycle pulse; begins a load (honoured in IDLE or DONE only)
//  wr_data       in   WORD_W  bitstream word; bit WORD_W-1 is shifted first
//  wr_valid      in   1       wr_data valid
//  wr_ready      out  1       word accepted on a cycle with wr_valid & wr_ready
//  ccff_head     out  1       serial config bit to chain head (registered)
//  chain_clk_en  out  1       registered; 1 = chain must clock this cycle, ccff_head is valid
//  busy          out  1       1 in LOAD/SHIFT
//  done          out  1       1 in DONE
//  bit_count     out  CNT_W   bits emitted since last start
//  crc_out       out  16      only with CCFF_CRC_EN
// BEHAVIOUR
//  Reset (prog_reset_n=0 at an edge): state=IDLE; ccff_head=0, chain_clk_en=0, wr_ready=0, busy=0, done=0, bit_count=0, both word buffers empty.
//  Storage: shift register SR plus one holding register HR (two-entry buffer), so a back-to-back stream gives gap-free shifting.
//  Words needed: NW = ceil(CHAIN_LEN/WORD_W); the word counter stops acceptance after NW words.
//  wr_ready = busy & HR empty & words_accepted<NW; combinational from state only (no path from wr_valid).
//  States:
//   IDLE : start -> LOAD, clears bit_count/word count.
//   LOAD : SR empty, waiting; an accepted word goes to SR directly -> SHIFT.
//   SHIFT: each cycle ccff_head<=SR[MSB], chain_clk_en<=1, SR<<=1, bit_count++.
//          When SR is exhausted (WORD_W bits) and HR is full, move HR->SR in the same edge (no bubble).
//          If HR is empty -> LOAD; chain_clk_en=0 on bubble cycles, and ccff_head holds its last value.
//          If bit_count reaches CHAIN_LEN -> DONE immediately; remaining SR bits are discarded (last-word padding).
//   DONE : done=1, chain_clk_en=0; held until start (-> LOAD, new load) or reset.
//  Simultaneous events: a word accepted while SR is exhausting goes straight to SR.
//  start while busy: ignored. wr_valid in IDLE/DONE: not accepted (wr_ready=0).
//  Latency: the first bit appears on ccff_head/chain_clk_en 1 cycle after the accepting edge of word 0.
//  Mid-load reset: the next edge forces chain_clk_en=0 and IDLE. The chain contents are then undefined and a full reload is required.
//  Bit order: word0[WORD_W-1] is the first bit in, so it ends at the chain tail.
// CONFIGURATION
//  CCFF_CRC_EN defined:
//   - CRC-16 (poly 0x1021, init 0xFFFF, no reflect, no xorout) over every emitted bit in shift order.
//   - Updated on the same edge the bit is emitted; reset to 0xFFFF on start and on reset.
//   - Exposed as crc_out and frozen in DONE.
//  Undefined: the crc_out port and all CRC logic are absent; behaviour is otherwise identical.
// TESTING (CHAIN_LEN=40, WORD_W=32)
//  1) Hold prog_reset_n=0 for 2 edges -> all outputs 0 and state IDLE; wr_valid=1 with no start -> wr_ready stays 0.
//  2) start, then 0xA5A5A5A5 and 0xFF000000 back-to-back -> chain_clk_en high for exactly 40 contiguous cycles.
//     ccff_head = 1,0,1,0,0,1,0,1 (x4) then 1 x8; done=1 the cycle after the 40th bit; bit_count=40.
//     Third word is never accepted.
//  3) As 2, but word1 is presented 5 cycles after SR empties -> 5 cycles with chain_clk_en=0; the 40-bit sequence is unchanged.
//  4) prog_reset_n=0 after 10 bits -> next edge: chain_clk_en=0, busy=0, bit_count=0; then start reloads correctly.
//  5) start pulse while in SHIFT -> ignored, bit_count keeps counting; start in DONE -> new load, bit_count restarts at 0.
//  6) CCFF_CRC_EN, stream of all-zero words -> crc_out in DONE equals the bench bitwise CRC-16 model over 40 zero bits.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Configuration-chain head driver: buffers bitstream words and shifts them MSB-first onto ccff_head.
// Define CCFF_CRC_EN to add a CRC-16 (0x1021) over the emitted bits on crc_out.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              ccff_head,
  output logic              chain_clk_en,
  output logic              busy,
  output logic              done,
`ifdef CCFF_CRC_EN
  output logic [15:0]       crc_out,
`endif
  output logic [CNT_W-1:0]  bit_count
);

  localparam int NW   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int SC_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [SC_W-1:0]   sr_cnt_q, sr_cnt_d;
  logic [WORD_W-1:0] hr_q, hr_d;
  logic              hr_full_q, hr_full_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              head_q, head_d;
  logic              clk_en_q, clk_en_d;
  logic              accept;
  logic              start_load;
  logic              emit;

  assign busy       = (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign done       = (state_q == S_DONE);
  // Ready depends only on registered state so there is no combinational path from wr_valid.
  assign wr_ready   = busy && !hr_full_q && (word_cnt_q < CNT_W'(NW));
  assign accept     = wr_valid && wr_ready;
  assign start_load = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign emit       = (state_q == S_SHIFT);

  assign ccff_head    = head_q;
  assign chain_clk_en = clk_en_q;
  assign bit_count    = bit_cnt_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    state_d    = state_q;
    sr_d       = sr_q;
    sr_cnt_d   = sr_cnt_q;
    hr_d       = hr_q;
    hr_full_d  = hr_full_q;
    word_cnt_d = word_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    head_d     = head_q;
    clk_en_d   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_load) begin
          state_d    = S_LOAD;
          sr_cnt_d   = '0;
          hr_full_d  = 1'b0;
          word_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end

      S_LOAD: begin
        if (accept) begin
          sr_d       = wr_data;
          sr_cnt_d   = SC_W'(WORD_W);
          word_cnt_d = word_cnt_q + CNT_W'(1);
          state_d    = S_SHIFT;
        end
      end

      S_SHIFT: begin
        head_d    = sr_q[WORD_W-1];
        clk_en_d  = 1'b1;
        sr_d      = {sr_q[WORD_W-2:0], 1'b0};
        sr_cnt_d  = sr_cnt_q - SC_W'(1);
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (accept) begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
        end

        if (bit_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
          // Last chain bit: whatever padding remains in the buffers is dropped.
          state_d   = S_DONE;
          sr_cnt_d  = '0;
          hr_full_d = 1'b0;
        end else if (sr_cnt_q == SC_W'(1)) begin
          if (hr_full_q) begin
            sr_d      = hr_q;
            sr_cnt_d  = SC_W'(WORD_W);
            hr_full_d = 1'b0;
          end else if (accept) begin
            sr_d     = wr_data;
            sr_cnt_d = SC_W'(WORD_W);
          end else begin
            state_d = S_LOAD;
          end
        end else if (accept) begin
          hr_d      = wr_data;
          hr_full_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!prog_reset_n) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      sr_cnt_q   <= '0;
      hr_q       <= '0;
      hr_full_q  <= 1'b0;
      word_cnt_q <= '0;
      bit_cnt_q  <= '0;
      head_q     <= 1'b0;
      clk_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      sr_cnt_q   <= sr_cnt_d;
      hr_q       <= hr_d;
      hr_full_q  <= hr_full_d;
      word_cnt_q <= word_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      head_q     <= head_d;
      clk_en_q   <= clk_en_d;
    end
  end

`ifdef CCFF_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic        crc_fb;

  assign crc_fb  = crc_q[15] ^ sr_q[WORD_W-1];
  assign crc_out = crc_q;

  always_comb begin
    crc_d = crc_q;
    if (start_load) begin
      crc_d = 16'hFFFF;
    end else if (emit) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      crc_q <= 16'hFFFF;
    end else begin
      crc_q <= crc_d;
    end
  end
`endif

endmodule
